fetch_decode_buffer: RTL and testbench
======================================

// Module: fetch_decode_buffer
// PURPOSE
// - Instruction queue between the fetch stage and decode: captures {pc, instruction} pairs each cycle fetch
//   presents a valid word, holds them while decode stalls, and drains them in order.
// - Drives back-pressure to fetch, so the PC holds when the queue is full.
// - Discards all queued work on a control-flow redirect (taken branch / jal / jalr).
// PARAMETERS
// - DataWidth  32  width of instruction and PC
// - Depth      2   queue entries; power of two, >= 2
// PORTS
// - clk             in   1          core clock; all state updates on rising edge
// - rst             in   1          synchronous, active-low reset
// - if_valid        in   1          fetch presents a valid instruction this cycle
// - if_instruction  in   DataWidth  fetched instruction word
// - if_pc           in   DataWidth  PC of if_instruction
// - if_ready        out  1          queue can accept this cycle; fetch holds PC while low
// - flush           in   1          redirect: discard queue contents and any push this cycle
// - id_valid        out  1          head entry valid for decode
// - id_instruction  out  DataWidth  head instruction; NOP when !id_valid
// - id_pc           out  DataWidth  head PC; 0 when !id_valid
// - id_ready        in   1          decode consumes the head this cycle
// - occupancy       out  $clog2(Depth)+1  entries currently held
// BEHAVIOUR
// - Reset (rst==0 at edge): rd_ptr=wr_ptr=0, count=0. While rst is low: if_ready=0, id_valid=0,
//   id_instruction=NOP (32'h0000_0013), id_pc=0, occupancy=0. Storage array is not reset.
// - push = if_valid & if_ready & ~flush; pop = id_valid & id_ready.
// - if_ready = rst & (count != Depth), derived combinationally from registered count only.
//   It never depends on id_ready: no pass-through when full.
// - id_valid = rst & (count != 0) & ~flush; id_instruction and id_pc show mem[rd_ptr] when
//   id_valid, else NOP / 0.
// - Latency: word pushed at edge N is visible on id_* from N+1. There is no same-cycle bypass.
// - Pointers are $clog2(Depth) bits and wrap naturally from Depth-1 to 0.
// - count: +1 on push only, -1 on pop only, unchanged on push & pop.
// - Full: if_ready=0, and if_valid is ignored. Fetch must hold its word and PC.
// - Empty: id_valid=0, and id_ready is ignored (no underflow).
// - Simultaneous push and pop at 0 < count < Depth: both occur and count is unchanged.
// - Flush wins over everything:
//   - at the next edge rd_ptr=wr_ptr=0 and count=0;
//   - the push in the flush cycle is dropped;
//   - id_valid is 0 during the flush cycle, so decode sees no pop.
// - Flush while empty or full: same result, empty next cycle.
// - if_valid=1 with flush=1: if_ready may read 1, but the word is not stored.
// - Reset mid-operation: all entries are discarded exactly as for flush; no partial drain.
// - Assertions:
//   - count <= Depth;
//   - no push when count==Depth;
//   - id_* stable while id_valid & ~id_ready & ~flush.
// STRUCTURE
// - rv32i_pkg: DataWidth default, localparam NOP = 32'h0000_0013,
//   typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
// - The storage array, pointers and count live in this module.
// - One optional sub-module, sync_fifo_ctrl, holds pointer and count logic only; it is reusable
//   for the LSU queue.
// - Instantiated between fetch (pc_address, instruction, valid) and decode. if_ready gates the
//   program counter's load/hold.
// TESTING
// - Reset: rst=0 for 2 cycles with if_valid=1 -> if_ready=0, id_valid=0, id_instruction=0x00000013,
//   occupancy=0; first push possible the cycle rst rises.
// - Stream: id_ready=1, push pc=0x00,0x04,0x08 with instr=0x00500093,0x00100113,0x002081B3 ->
//   each appears on id_* one cycle later, in order, with occupancy toggling 0/1.
// - Stall/full: id_ready=0, push 0x00,0x04 -> occupancy=2, if_ready=0, pc=0x08 offered and not
//   stored. Release id_ready -> id_pc=0x00 then 0x04, and if_ready returns 1 after the first pop.
// - Simultaneous: occupancy=1 (pc 0x10), push 0x14 with id_ready=1 -> next cycle occupancy=1,
//   id_pc=0x14.
// - Flush: occupancy=2 (0x20,0x24), flush=1 with if_valid=1 pc=0x28 -> id_valid=0 that cycle and
//   occupancy=0 next. Push target pc=0x100 -> id_pc=0x100 one cycle later, with no stale 0x20/0x24/0x28.
// - Wrap: run 10 push/pop pairs with Depth=2 and random id_ready -> PCs exit strictly in push order,
//   and no assertion fires.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: default datapath width, canonical NOP and queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int DATA_WIDTH = 32;

    // addi x0, x0, 0 -- what decode sees whenever no real instruction is present
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for a power-of-two circular queue; storage lives in the user.
// Latency: pointers and count update on the edge that samples push/pop/flush.
// Backpressure: none itself; the caller must never push when full or pop when empty.
//
// Ports: clk, i_rst_n (sync, active-low), i_push, i_pop, i_flush,
//        o_rd_ptr / o_wr_ptr (storage indices), o_count (entries held).
module sync_fifo_ctrl #(
    parameter int Depth = 2,
    parameter int PtrW  = $clog2(Depth),
    parameter int CntW  = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [PtrW-1:0] o_rd_ptr,
    output logic [PtrW-1:0] o_wr_ptr,
    output logic [CntW-1:0] o_count
);

    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    // Reset and flush have identical effect: the queue restarts empty at index 0.
    // Pointers wrap for free because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (i_push && !i_pop)      r_count <= r_count + CntW'(1);
            else if (i_pop && !i_push) r_count <= r_count - CntW'(1);
        end
    end

    assign o_rd_ptr = r_rd_ptr;
    assign o_wr_ptr = r_wr_ptr;
    assign o_count  = r_count;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Instruction queue between fetch and decode; {pc, instr} pairs drain in order, flush discards all.
// Latency: a word pushed at edge N is presented to decode from N+1 (no bypass).
// Backpressure: if_ready drops when full, from registered count only (no pass-through on pop).
//
// Ports: clk, rst (sync, active-low);
//        fetch side  if_valid, if_instruction, if_pc -> if_ready;
//        flush (redirect);
//        decode side id_valid, id_instruction, id_pc <- id_ready; occupancy.
module fetch_decode_buffer
    import rv32i_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int Depth     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [DataWidth-1:0]     if_instruction,
    input  logic [DataWidth-1:0]     if_pc,
    output logic                     if_ready,
    input  logic                     flush,
    output logic                     id_valid,
    output logic [DataWidth-1:0]     id_instruction,
    output logic [DataWidth-1:0]     id_pc,
    input  logic                     id_ready,
    output logic [$clog2(Depth):0]   occupancy
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] FULL_CNT = CntW'(Depth);

    logic [PtrW-1:0]        w_rd_ptr;
    logic [PtrW-1:0]        w_wr_ptr;
    logic [CntW-1:0]        w_count;
    logic                   w_if_ready;
    logic                   w_id_valid;
    logic                   w_push;
    logic                   w_pop;
    logic [2*DataWidth-1:0] w_head;

    // Entry layout {pc, instr}; contents are don't-care until written, so no reset.
    logic [2*DataWidth-1:0] r_mem [Depth];

    assign w_if_ready = rst && (w_count != FULL_CNT);
    // Masking with flush guarantees decode never consumes an entry that is being discarded.
    assign w_id_valid = rst && (w_count != '0) && !flush;
    assign w_push     = if_valid && w_if_ready && !flush;
    assign w_pop      = w_id_valid && id_ready;

    sync_fifo_ctrl #(
        .Depth (Depth),
        .PtrW  (PtrW),
        .CntW  (CntW)
    ) u_ctrl (
        .clk      (clk),
        .i_rst_n  (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (flush),
        .o_rd_ptr (w_rd_ptr),
        .o_wr_ptr (w_wr_ptr),
        .o_count  (w_count)
    );

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_ptr] <= {if_pc, if_instruction};
    end

    assign w_head = r_mem[w_rd_ptr];

    assign if_ready       = w_if_ready;
    assign id_valid       = w_id_valid;
    assign id_pc          = w_id_valid ? w_head[2*DataWidth-1:DataWidth] : '0;
    assign id_instruction = w_id_valid ? w_head[DataWidth-1:0] : DataWidth'(NOP);
    // Forced to zero while reset is held, even before the reset edge clears the count.
    assign occupancy      = rst ? w_count : '0;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        w_count <= FULL_CNT);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        w_push |-> (w_count != FULL_CNT));

    // A stalled head must hold until taken, unless a redirect discards it.
    a_head_stable: assert property (@(posedge clk) disable iff (!rst)
        (w_id_valid && !id_ready) |=>
            (flush || (id_valid && id_pc == $past(id_pc)
                       && id_instruction == $past(id_instruction))));

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;
    import rv32i_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instruction = '0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_decode_buffer #(.DataWidth(32), .Depth(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_ready       (id_ready),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of accepted words.
    fetch_entry_t mq[$];
    bit m_pop, m_push;

    always @(posedge clk) begin
        if (!rst || flush) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() != 0) && id_ready;
            m_push = if_valid && (mq.size() < DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{pc: if_pc, instr: if_instruction});
        end
    end

    // Every-cycle comparison, sampled mid-low-phase after inputs settle.
    logic        e_rdy, e_vld;
    logic [31:0] e_pc, e_ins;
    logic [1:0]  e_occ;

    always @(negedge clk) begin
        #1;
        e_rdy = rst && (mq.size() != DEPTH);
        e_vld = rst && (mq.size() != 0) && !flush;
        e_pc  = e_vld ? mq[0].pc : 32'h0;
        e_ins = e_vld ? mq[0].instr : NOP;
        e_occ = rst ? 2'(mq.size()) : 2'd0;
        chk("m_if_ready", 64'(if_ready), 64'(e_rdy));
        chk("m_id_valid", 64'(id_valid), 64'(e_vld));
        chk("m_id_pc", 64'(id_pc), 64'(e_pc));
        chk("m_id_instr", 64'(id_instruction), 64'(e_ins));
        chk("m_occupancy", 64'(occupancy), 64'(e_occ));
    end

    // Apply one cycle of inputs on the falling edge, then let outputs settle.
    task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy, input logic fl);
        @(negedge clk);
        rst = r; if_valid = v; if_pc = pc; if_instruction = ins;
        id_ready = rdy; flush = fl;
        #1;
    endtask

    logic [31:0] rpc;

    initial begin
        // Reset held with fetch presenting a word
        drive(0, 1, 32'h0, 32'h0050_0093, 0, 0);
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        drive(0, 1, 32'h0, 32'h0050_0093, 0, 0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_instr", 64'(id_instruction), 64'h13);

        // Stream with gaps: occupancy toggles 0/1
        drive(1, 1, 32'h00, 32'h0050_0093, 1, 0);
        chk("rel_if_ready", 64'(if_ready), 64'd1);
        drive(1, 0, 32'h04, 32'h0010_0113, 1, 0);
        chk("s0_pc", 64'(id_pc), 64'h00);
        chk("s0_instr", 64'(id_instruction), 64'h0050_0093);
        chk("s0_occ", 64'(occupancy), 64'd1);
        drive(1, 1, 32'h04, 32'h0010_0113, 1, 0);
        chk("s1_gap_occ", 64'(occupancy), 64'd0);
        drive(1, 1, 32'h08, 32'h0020_81B3, 1, 0);
        chk("s1_pc", 64'(id_pc), 64'h04);
        drive(1, 0, 32'h0C, 32'h0, 1, 0);
        chk("s2_pc", 64'(id_pc), 64'h08);
        chk("s2_instr", 64'(id_instruction), 64'h0020_81B3);
        drive(1, 0, 32'h0, 32'h0, 1, 0);

        // Stall until full; 0x08 offered and refused
        drive(1, 1, 32'h00, 32'h1111_0000, 0, 0);
        drive(1, 1, 32'h04, 32'h1111_0004, 0, 0);
        drive(1, 1, 32'h08, 32'h1111_0008, 0, 0);
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_if_ready", 64'(if_ready), 64'd0);
        drive(1, 0, 32'h08, 32'h1111_0008, 1, 0);
        chk("drain0_pc", 64'(id_pc), 64'h00);
        chk("drain0_if_ready", 64'(if_ready), 64'd0);
        drive(1, 0, 32'h08, 32'h1111_0008, 1, 0);
        chk("drain1_pc", 64'(id_pc), 64'h04);
        chk("drain1_if_ready", 64'(if_ready), 64'd1);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        chk("drain_empty", 64'(id_valid), 64'd0);

        // Simultaneous push and pop at occupancy 1
        drive(1, 1, 32'h10, 32'h2222_0010, 0, 0);
        drive(1, 1, 32'h14, 32'h2222_0014, 1, 0);
        chk("sim_occ_before", 64'(occupancy), 64'd1);
        chk("sim_pc_before", 64'(id_pc), 64'h10);
        drive(1, 0, 32'h0, 32'h0, 0, 0);
        chk("sim_occ_after", 64'(occupancy), 64'd1);
        chk("sim_pc_after", 64'(id_pc), 64'h14);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        drive(1, 0, 32'h0, 32'h0, 1, 0);

        // Flush while full, with a push offered in the flush cycle
        drive(1, 1, 32'h20, 32'h3333_0020, 0, 0);
        drive(1, 1, 32'h24, 32'h3333_0024, 0, 0);
        drive(1, 1, 32'h28, 32'h3333_0028, 1, 1);
        chk("fl_id_valid", 64'(id_valid), 64'd0);
        drive(1, 1, 32'h100, 32'h3333_0100, 1, 0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        chk("fl_target_pc", 64'(id_pc), 64'h100);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        chk("fl_no_stale", 64'(id_valid), 64'd0);

        // Reset mid-operation discards everything
        drive(1, 1, 32'h40, 32'h4444_0040, 0, 0);
        drive(1, 1, 32'h44, 32'h4444_0044, 0, 0);
        drive(0, 1, 32'h48, 32'h4444_0048, 1, 0);
        chk("mrst_occ", 64'(occupancy), 64'd0);
        chk("mrst_id_pc", 64'(id_pc), 64'h0);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        chk("mrst_empty", 64'(id_valid), 64'd0);

        // Randomised traffic: ordering, wrap, occasional flush, all checked by the model
        rpc = 32'h200;
        for (int i = 0; i < 300; i++) begin
            drive(1, 1'($urandom % 2), rpc, rpc ^ 32'hA5A5_0000,
                  1'($urandom % 2), ($urandom % 20) == 0);
            if (if_valid && if_ready && !flush) rpc = rpc + 32'd4;
        end
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        drive(1, 0, 32'h0, 32'h0, 1, 0);
        chk("end_empty", 64'(occupancy), 64'd0);

        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
